// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler: source select, idle select pattern, frame size.
// Pure declarations; no latency or backpressure of its own.
package disp_pkg;

  typedef enum logic [1:0] {
    SRC_TIME  = 2'd0,
    SRC_ALARM = 2'd1,
    SRC_MSG   = 2'd2
  } src_e;

  localparam logic [7:0] SEL_NONE    = 8'hFF;
  localparam int         FRAME_SLOTS = 8;

  // Number of lit slots per frame; TIME accepts only 6, anything else means a full frame.
  function automatic logic [3:0] frame_len(src_e s, logic [3:0] time_n);
    case (s)
      SRC_ALARM: return 4'd6;
      SRC_MSG:   return 4'd8;
      default:   return (time_n == 4'd6) ? 4'd6 : 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/scan_slot_counter.sv
// Slot index for the 8-slot scan frame; slot is the slot shown by the next scan_tick, wrap flags the tick showing slot 0.
// Advances in the cycle scan_tick is sampled; no backpressure, every scan_tick is consumed.
module scan_slot_counter
  import disp_pkg::*;
(
  input  logic       CP,
  input  logic       CR,
  input  logic       scan_tick,
  output logic [2:0] slot,
  output logic       wrap
);

  localparam logic [2:0] LAST_SLOT = 3'(FRAME_SLOTS - 1);

  logic [2:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (scan_tick) begin
      slot_d = (slot_q == LAST_SLOT) ? 3'd0 : slot_q + 3'd1;
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      slot_q <= 3'd0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign wrap = scan_tick && (slot_q == 3'd0);

endmodule

// File: rtl/display_scheduler.sv
// Multiplexed 8-digit display scheduler choosing TIME/ALARM/MSG per frame; select/digit update one CP after scan_tick.
// No backpressure: strobes are consumed as they come. DISP_LZ_BLANK_EN blanks a leading zero in TIME/ALARM frames.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int MSG_HOLD = 3
) (
  input  logic        CP,
  input  logic        CR,
  input  logic        scan_tick,
  input  logic        sec_tick,
  input  logic [31:0] time_bcd,
  input  logic [3:0]  time_n,
  input  logic        alarm_req,
  input  logic [23:0] alarm_bcd,
  input  logic        msg_req,
  input  logic [31:0] msg_bcd,
  output logic [3:0]  digit,
  output logic [7:0]  select,
  output logic [1:0]  src,
  output logic        msg_grant
);

  localparam logic [3:0] HOLD_INIT = 4'(MSG_HOLD);

  logic [2:0] slot;
  logic       wrap;

  src_e        src_q, src_d, next_src;
  logic        grant_q, grant_d;
  logic [3:0]  hold_q, hold_d;
  logic        pending_q, pending_d;
  logic [31:0] frame_q, frame_d;
  logic [3:0]  len_q, len_d;
  logic [7:0]  select_q, select_d;
  logic [3:0]  digit_q, digit_d;
  logic        in_msg, stay_msg, active;
  logic [31:0] shifted;
  logic [3:0]  nib;

  scan_slot_counter u_slot (
    .CP        (CP),
    .CR        (CR),
    .scan_tick (scan_tick),
    .slot      (slot),
    .wrap      (wrap)
  );

  always_comb begin
    src_d     = src_q;
    grant_d   = grant_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    frame_d   = frame_q;
    len_d     = len_q;
    select_d  = select_q;
    digit_d   = digit_q;
    next_src  = src_q;
    in_msg    = (src_q == SRC_MSG);
    stay_msg  = in_msg ? (hold_q != 4'd0 || msg_req) : (pending_q || msg_req);
    shifted   = '0;
    nib       = '0;
    active    = 1'b0;

    // While showing a message a new request extends it instead of queueing behind it.
    if (in_msg) begin
      pending_d = 1'b0;
      if (msg_req) begin
        hold_d = HOLD_INIT;
      end else if (sec_tick && hold_q != 4'd0) begin
        hold_d = hold_q - 4'd1;
      end
    end else if (msg_req) begin
      pending_d = 1'b1;
    end

    if (wrap) begin
      if (stay_msg) begin
        next_src = SRC_MSG;
      end else if (alarm_req) begin
        next_src = SRC_ALARM;
      end else begin
        next_src = SRC_TIME;
      end
      if (next_src == SRC_MSG && !in_msg) begin
        hold_d    = HOLD_INIT;
        pending_d = 1'b0;
      end
      src_d   = next_src;
      grant_d = (next_src == SRC_MSG);
      case (next_src)
        SRC_ALARM: frame_d = {alarm_bcd, 8'h00};
        SRC_MSG:   frame_d = msg_bcd;
        default:   frame_d = time_bcd;
      endcase
      len_d = frame_len(next_src, time_n);
    end

    if (scan_tick) begin
      shifted = frame_d << {slot, 2'b00};
      nib     = shifted[31:28];
      active  = ({1'b0, slot} < len_d);
`ifdef DISP_LZ_BLANK_EN
      if (slot == 3'd0 && src_d != SRC_MSG && nib == 4'd0) begin
        active = 1'b0;
      end
`endif
      if (active) begin
        select_d = ~(8'h80 >> slot);
        digit_d  = nib;
      end else begin
        select_d = SEL_NONE;
      end
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      src_q     <= SRC_TIME;
      grant_q   <= 1'b0;
      hold_q    <= 4'd0;
      pending_q <= 1'b0;
      frame_q   <= '0;
      len_q     <= 4'd8;
      select_q  <= SEL_NONE;
      digit_q   <= 4'd0;
    end else begin
      src_q     <= src_d;
      grant_q   <= grant_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      len_q     <= len_d;
      select_q  <= select_d;
      digit_q   <= digit_d;
    end
  end

  assign src       = src_q;
  assign msg_grant = grant_q;
  assign select    = select_q;
  assign digit     = digit_q;

endmodule
